// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryptor: the key is expanded forward to rk10, then ten inverse rounds run
// one per cycle while the key register steps back a round each cycle. Optional: AES_DEC_KEY_CACHE_EN.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] q
);
    // Row 0 of the table sits in the top bits, so entry a lives at index ~a.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign q = SBOX[~a];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] q
);
    localparam logic [255:0][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    assign q = ISBOX[~a];
endmodule

module aes_128_decrypt_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] inp_data,
    input  logic [127:0] inp_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [1:0]   dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready depends only on state and out_valid/out_data hold until out_ready is seen.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] blk_q;
    logic [127:0] key_q;
    logic [3:0]   cnt_q;
    logic         cache_hit;
    logic [127:0] hit_rk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m_b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m_d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m_e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {m_e(a0) ^ m_b(a1) ^ m_d(a2) ^ m_9(a3),
                m_9(a0) ^ m_e(a1) ^ m_b(a2) ^ m_d(a3),
                m_d(a0) ^ m_9(a1) ^ m_e(a2) ^ m_b(a3),
                m_b(a0) ^ m_d(a1) ^ m_9(a2) ^ m_e(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Key path: one set of four S-boxes serves both the forward and the backward step.
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [31:0]  back_w3, sb_in, sb_rot, sub_rot, rcon_w;
    logic [3:0]   rcon_idx;
    logic [127:0] key_fwd, key_bwd;
    logic [31:0]  f0, f1, f2, f3;

    assign {kw0, kw1, kw2, kw3} = key_q;
    assign back_w3  = kw3 ^ kw2;
    assign sb_in    = (state_q == ROUND) ? back_w3 : kw3;
    assign sb_rot   = {sb_in[23:0], sb_in[31:24]};
    assign rcon_idx = (state_q == ROUND) ? cnt_q + 4'd1 : cnt_q;
    assign rcon_w   = {rcon(rcon_idx), 24'h000000};

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (
            .a(sb_rot[31-8*j -: 8]),
            .q(sub_rot[31-8*j -: 8])
        );
    end

    assign f0      = kw0 ^ sub_rot ^ rcon_w;
    assign f1      = kw1 ^ f0;
    assign f2      = kw2 ^ f1;
    assign f3      = kw3 ^ f2;
    assign key_fwd = {f0, f1, f2, f3};
    assign key_bwd = {kw0 ^ sub_rot ^ rcon_w, kw1 ^ kw0, kw2 ^ kw1, back_w3};

    // Round path: InvShiftRows is pure wiring in front of the 16 inverse S-boxes.
    logic [127:0] isr, isb, ark, imc, round_out;

    for (genvar b = 0; b < 16; b++) begin : g_inv_byte
        localparam int ROW = b % 4;
        localparam int SRC = 4 * (((b / 4) + 4 - ROW) % 4) + ROW;
        assign isr[127-8*b -: 8] = blk_q[127-8*SRC -: 8];
        aes_inv_sbox u_inv_sbox (
            .a(isr[127-8*b -: 8]),
            .q(isb[127-8*b -: 8])
        );
    end

    assign ark       = isb ^ key_bwd;
    assign imc       = {inv_mix_col(ark[127:96]), inv_mix_col(ark[95:64]),
                        inv_mix_col(ark[63:32]),  inv_mix_col(ark[31:0])};
    assign round_out = (cnt_q == 4'd0) ? ark : imc;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key_q;
    logic [127:0] cache_rk_q;
    logic         cache_vld_q;

    assign cache_hit = cache_vld_q && (inp_key == cache_key_q);
    assign hit_rk    = cache_rk_q;

    // A miss invalidates at accept so an aborted expansion can never pair a key with a stale rk10.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
        end else if (state_q == IDLE && in_valid && !cache_hit) begin
            cache_key_q <= inp_key;
            cache_vld_q <= 1'b0;
        end else if (state_q == KEYEXP && cnt_q == 4'd10) begin
            cache_rk_q  <= key_fwd;
            cache_vld_q <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_rk    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = cache_hit ? ROUND : KEYEXP;
            KEYEXP:  if (cnt_q == 4'd10) state_d = ROUND;
            ROUND:   if (cnt_q == 4'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q    <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            out_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (cache_hit) begin
                            blk_q <= inp_data ^ hit_rk;
                            key_q <= hit_rk;
                            cnt_q <= 4'd9;
                        end else begin
                            blk_q <= inp_data;
                            key_q <= inp_key;
                            cnt_q <= 4'd1;
                        end
                    end
                end
                KEYEXP: begin
                    key_q <= key_fwd;
                    if (cnt_q == 4'd10) begin
                        blk_q <= blk_q ^ key_fwd;
                        cnt_q <= 4'd9;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    blk_q <= round_out;
                    key_q <= key_bwd;
                    if (cnt_q == 4'd0) begin
                        out_data <= round_out;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Bench for aes_128_decrypt_iter: FIPS vectors, backpressure, reset abort and a randomized
// round-trip against an AES-128 encryption model built from GF(2^8) arithmetic.
module tb_aes_128_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] inp_data;
  logic [127:0] inp_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   dbg_state;

  aes_128_decrypt_iter dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inp_data (inp_data),
    .inp_key  (inp_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  localparam int LAT_MISS = 21;
  localparam int LAT_HIT  = CACHE_EN ? 11 : 21;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs[5];

  int n_cmp = 0;
  int n_err = 0;

  // Model of the key cache: last completed key, valid until reset.
  logic [127:0] cache_key;
  bit           cache_ok;

  logic [7:0] sbox_t[256];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_rk(input logic [127:0] k, input int rnd);
    logic [7:0]  rc;
    logic [31:0] w[4];
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]}
        ^ {rc, 24'h000000};
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s[16], t[16], u[16], mcoef[4];
    logic [127:0] rk, res;
    mcoef = '{8'h02, 8'h03, 8'h01, 8'h01};
    rk = key;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      rk = next_rk(rk, r);
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) begin
            u[4*c+j] = 8'h00;
            for (int k = 0; k < 4; k++) u[4*c+j] = u[4*c+j] ^ gmul(mcoef[(k - j + 4) % 4], t[4*c+k]);
          end
        end
      end else begin
        for (int i = 0; i < 16; i++) u[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = u[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
    return (CACHE_EN && cache_ok && k == cache_key) ? LAT_HIT : LAT_MISS;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drivers ----------------
  // Presents a block at the current negedge; returns in the cycle whose next edge accepts it.
  task automatic start_block(input logic [127:0] k, input logic [127:0] c);
    int guard;
    guard = 0;
    inp_key  = k;
    inp_data = c;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 128'(in_ready), 128'd1);
  endtask

  // Counts cycles until out_valid; the handshake cycle is cycle 0. Random in_valid while busy.
  task automatic wait_out(output int lat, output logic [127:0] d);
    int busy_err;
    busy_err = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) begin
        if (in_ready) busy_err++;
        in_valid = 1'($urandom_range(0, 1));
        inp_data = rnd128();
        inp_key  = rnd128();
      end
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    check("busy_in_ready", 128'(busy_err), 128'd0);
    check("out_valid_timeout", 128'(out_valid), 128'd1);
    d = out_data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [127:0] d;
    logic [127:0] k, p, c, hold;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inp_data = '0; inp_key = '0;
    cache_ok = 1'b0; cache_key = '0;
    build_sbox();

    vecs[0] = '{C1_KEY, C1_CT, C1_PT, LAT_MISS};
    vecs[1] = '{C1_KEY, C1_CT, C1_PT, LAT_HIT};
    vecs[2] = '{B_KEY,  B_CT,  B_PT,  LAT_MISS};
    vecs[3] = '{B_KEY,  B_CT,  B_PT,  LAT_HIT};
    vecs[4] = '{C1_KEY, C1_CT, C1_PT, LAT_MISS};

    repeat (3) @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_out_data", out_data, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS vectors, back to back with out_ready held high
    for (int i = 0; i < 5; i++) begin
      start_block(vecs[i].key, vecs[i].ct);
      wait_out(lat, d);
      check($sformatf("vec%0d_data", i), d, vecs[i].pt);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      cache_key = vecs[i].key; cache_ok = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_idle_in_ready", i), 128'(in_ready), 128'd1);
      check($sformatf("vec%0d_idle_out_valid", i), 128'(out_valid), 128'd0);
    end

    // Backpressure: 50 cycles in DONE with out_ready low and in_valid noise
    out_ready = 1'b0;
    start_block(C1_KEY, C1_CT);
    wait_out(lat, d);
    check("bp_data", d, C1_PT);
    check("bp_latency", 128'(lat), 128'(exp_lat(C1_KEY)));
    cache_key = C1_KEY; cache_ok = 1'b1;
    hold = C1_PT;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; inp_data = rnd128(); inp_key = rnd128();
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_data", out_data, hold);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);

    // Reset in the middle of the inverse rounds (cycle 15), then a clean block
    start_block(B_KEY, B_CT);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cache_ok = 1'b0;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    start_block(C1_KEY, C1_CT);
    wait_out(lat, d);
    check("post_rst_data", d, C1_PT);
    check("post_rst_latency", 128'(lat), 128'(LAT_MISS));
    cache_key = C1_KEY; cache_ok = 1'b1;
    @(negedge clk);

    // Randomized round trip through the encryption model; keys sometimes repeat
    k = C1_KEY;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) != 0) k = rnd128();
      p = rnd128();
      c = encrypt(p, k);
      start_block(k, c);
      wait_out(lat, d);
      check($sformatf("rt%0d_data", n), d, p);
      check($sformatf("rt%0d_latency", n), 128'(lat), 128'(exp_lat(k)));
      cache_key = k; cache_ok = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
